// File: rtl/mvp_pkg.sv
// Shared types for the bit-serial matrix-vector product: arithmetic modes,
// controller states and the precision-field width helper.
package mvp_pkg;

    typedef enum logic [1:0] {
        MODE_UNSIGNED = 2'b00,
        MODE_BIPOLAR  = 2'b01,
        MODE_SIGNED   = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Precision fields must hold the value MAXPREC itself, hence the extra bit.
    function automatic int pw_of(input int maxprec);
        return $clog2(maxprec) + 1;
    endfunction

endpackage

// File: rtl/mvp_serial_if.sv
// Plane-pair input stream and row-result output stream of mvp_serial.
interface mvp_serial_if #(
    parameter int N    = 64,
    parameter int ACCW = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [N*N-1:0]      W;
    logic [N-1:0]        D;
    logic                out_valid;
    logic                out_ready;
    logic [N*ACCW-1:0]   S;

    modport master (
        output in_valid, W, D, out_ready,
        input  in_ready, out_valid, S
    );

    modport slave (
        input  in_valid, W, D, out_ready,
        output in_ready, out_valid, S
    );
endinterface

// File: rtl/vvp_acc.sv
// One row of the bit-serial product: popcount term, stage-1 register and
// shift-accumulator. Define MVP_SATURATE_EN for a saturating accumulator.
module vvp_acc
    import mvp_pkg::*;
#(
    parameter int N    = 64,
    parameter int ACCW = 32,
    parameter int KW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            ld,
    input  logic            v1,
    input  mode_e           mode,
    input  logic [N-1:0]    w_row,
    input  logic [N-1:0]    d,
    input  logic [KW-1:0]   k,
    input  logic            neg,
`ifdef MVP_SATURATE_EN
    output logic            sat,
`endif
    output logic [ACCW-1:0] acc
);
    localparam int CW = $clog2(N) + 1;
    localparam int TW = CW + 1;

    logic [N-1:0]    bits;
    logic [CW-1:0]   pc;
    logic [TW-1:0]   term_d;
    logic [TW-1:0]   term_q;
    logic [ACCW-1:0] shifted;
    logic [ACCW-1:0] addend;
    logic [ACCW-1:0] acc_d;
    logic            ovf;

    // Bipolar counts agreements (+1 each) so the term is 2*agree - N.
    always_comb begin
        bits = (mode == MODE_BIPOLAR) ? ~(w_row ^ d) : (w_row & d);
        pc   = '0;
        for (int c = 0; c < N; c++) begin
            pc = pc + CW'(bits[c]);
        end
        term_d = (mode == MODE_BIPOLAR) ? ({pc, 1'b0} - TW'(N)) : {1'b0, pc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_q <= '0;
        end else if (clr) begin
            term_q <= '0;
        end else if (ld) begin
            term_q <= term_d;
        end
    end

    always_comb begin
        shifted = {{(ACCW-TW){term_q[TW-1]}}, term_q} << k;
        addend  = neg ? -shifted : shifted;
`ifdef MVP_SATURATE_EN
        begin
            logic [ACCW:0] wide;
            wide = {acc[ACCW-1], acc} + {addend[ACCW-1], addend};
            ovf  = wide[ACCW] ^ wide[ACCW-1];
            if (!ovf) begin
                acc_d = wide[ACCW-1:0];
            end else if (wide[ACCW]) begin
                acc_d = {1'b1, {(ACCW-1){1'b0}}};
            end else begin
                acc_d = {1'b0, {(ACCW-1){1'b1}}};
            end
        end
`else
        ovf   = 1'b0;
        acc_d = acc + addend;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (v1) begin
            acc <= acc_d;
        end
    end

`ifdef MVP_SATURATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (clr) begin
            sat <= 1'b0;
        end else if (v1 && ovf) begin
            sat <= 1'b1;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif

endmodule

// File: rtl/mvp_serial.sv
// Bit-serial multi-precision matrix-vector product controller: job FSM, beat
// counters and handshakes around N row accumulators. MVP_SATURATE_EN adds sat.
module mvp_serial
    import mvp_pkg::*;
#(
    parameter  int N       = 64,
    parameter  int ACCW    = 32,
    parameter  int MAXPREC = 8,
    localparam int PW      = pw_of(MAXPREC),
    localparam int KW      = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] wprec,
    input  logic [PW-1:0] dprec,
    output logic          busy,
`ifdef MVP_SATURATE_EN
    output logic          sat,
`endif
    mvp_serial_if.slave   bus
);
    state_e        state_q, state_d;
    mode_e         mode_q;
    logic [PW-1:0] wp_q, dp_q, i_q, j_q;
    logic [KW-1:0] k_q;
    logic          neg_q, v1_q;
    logic          go, accept, last_beat, neg_d;
    logic [N*ACCW-1:0] s_all;

    function automatic logic [PW-1:0] clamp_prec(input logic [PW-1:0] p);
        if (p == '0) return PW'(1);
        else if (p > PW'(MAXPREC)) return PW'(MAXPREC);
        else return p;
    endfunction

    assign go        = (state_q == IDLE) && start;
    assign accept    = (state_q == RUN) && bus.in_valid;
    assign last_beat = (i_q == wp_q - PW'(1)) && (j_q == dp_q - PW'(1));
    // Cross terms between exactly one sign plane and an ordinary plane are negative.
    assign neg_d     = (mode_q == MODE_SIGNED) &&
                       (((i_q == wp_q - PW'(1)) && (wp_q > PW'(1))) ^
                        ((j_q == dp_q - PW'(1)) && (dp_q > PW'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (bus.in_valid && last_beat) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_UNSIGNED;
            wp_q   <= PW'(1);
            dp_q   <= PW'(1);
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            neg_q  <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= accept;
            if (go) begin
                mode_q <= mode_e'(mode);
                wp_q   <= clamp_prec(wprec);
                dp_q   <= clamp_prec(dprec);
                i_q    <= '0;
                j_q    <= '0;
            end else if (accept) begin
                k_q   <= {1'b0, i_q} + {1'b0, j_q};
                neg_q <= neg_d;
                if (j_q == dp_q - PW'(1)) begin
                    j_q <= '0;
                    i_q <= i_q + PW'(1);
                end else begin
                    j_q <= j_q + PW'(1);
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign bus.S         = s_all;

`ifdef MVP_SATURATE_EN
    logic [N-1:0] sat_rows;
    assign sat = |sat_rows;
`endif

    for (genvar r = 0; r < N; r++) begin : g_row
        vvp_acc #(.N(N), .ACCW(ACCW), .KW(KW)) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (go),
            .ld    (accept),
            .v1    (v1_q),
            .mode  (mode_q),
            .w_row (bus.W[r*N +: N]),
            .d     (bus.D),
            .k     (k_q),
            .neg   (neg_q),
`ifdef MVP_SATURATE_EN
            .sat   (sat_rows[r]),
`endif
            .acc   (s_all[r*ACCW +: ACCW])
        );
    end

endmodule

// File: tb/tb_mvp_serial.sv
// Self-checking bench for mvp_serial: directed and random jobs compared with an
// operand-value reference model (S_r = sum_c w_rc * d_c).
module tb_mvp_serial;
    import mvp_pkg::*;

    localparam int N       = 64;
    localparam int ACCW    = 32;
    localparam int MAXPREC = 8;
    localparam int PW      = pw_of(MAXPREC);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [PW-1:0] wprec = PW'(1);
    logic [PW-1:0] dprec = PW'(1);
    logic          busy;
`ifdef MVP_SATURATE_EN
    logic          sat;
`endif

    mvp_serial_if #(.N(N), .ACCW(ACCW)) bus ();

    mvp_serial #(.N(N), .ACCW(ACCW), .MAXPREC(MAXPREC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .wprec (wprec),
        .dprec (dprec),
        .busy  (busy),
`ifdef MVP_SATURATE_EN
        .sat   (sat),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int beats  = 0;
    int expS [N];
    logic [N*N-1:0] wpl [MAXPREC];
    logic [N-1:0]   dpl [MAXPREC];

    always @(posedge clk) if (bus.in_valid && bus.in_ready) beats++;

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic signed [63:0] rowS(input int r);
        return $signed(bus.S[r*ACCW +: ACCW]);
    endfunction

    function automatic int effPrec(input int p);
        if (p == 0) return 1;
        if (p > MAXPREC) return MAXPREC;
        return p;
    endfunction

    // Numeric value of one operand from its bit planes under the mode's encoding.
    function automatic longint opVal(input mode_e m, input int p, input logic [MAXPREC-1:0] b);
        longint v = 0;
        for (int i = 0; i < p; i++) begin
            if (m == MODE_BIPOLAR) v += (b[i] ? 64'sd1 : -64'sd1) * (longint'(1) << i);
            else if (b[i]) v += longint'(1) << i;
        end
        if (m == MODE_SIGNED && p > 1 && b[p-1]) v -= longint'(1) << p;
        return v;
    endfunction

    task automatic computeModel(input mode_e m, input int wp, input int dp);
        for (int r = 0; r < N; r++) begin
            longint sum = 0;
            for (int c = 0; c < N; c++) begin
                logic [MAXPREC-1:0] wb = '0;
                logic [MAXPREC-1:0] db = '0;
                for (int p = 0; p < MAXPREC; p++) begin
                    wb[p] = wpl[p][r*N + c];
                    db[p] = dpl[p][c];
                end
                sum += opVal(m, wp, wb) * opVal(m, dp, db);
            end
            expS[r] = int'(sum);
        end
    endtask

    task automatic clearPlanes();
        for (int p = 0; p < MAXPREC; p++) begin
            wpl[p] = '0;
            dpl[p] = '0;
        end
    endtask

    task automatic randomPlanes();
        for (int p = 0; p < MAXPREC; p++) begin
            for (int w = 0; w < N*N/32; w++) wpl[p][w*32 +: 32] = $urandom;
            dpl[p] = {$urandom, $urandom};
        end
    endtask

    task automatic checkRows(input string tag);
        for (int r = 0; r < N; r++) checkOutput($sformatf("%s_row%0d", tag, r), rowS(r), expS[r]);
    endtask

    // gapMode: 0 = back-to-back beats, 1 = idle cycle before every beat, 2 = random idles.
    task automatic applyStimulus(input string tag, input mode_e m, input int wpr, input int dpr,
                                 input int gapMode);
        int wp = effPrec(wpr);
        int dp = effPrec(dpr);
        computeModel(m, wp, dp);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        wprec = PW'(wpr);
        dprec = PW'(dpr);
        beats = 0;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy"}, busy, 1);
        for (int i = 0; i < wp; i++) begin
            for (int j = 0; j < dp; j++) begin
                if (gapMode == 1 || (gapMode == 2 && $urandom_range(1) == 1)) begin
                    bus.in_valid = 1'b0;
                    bus.D = {$urandom, $urandom};
                    @(negedge clk);
                end
                bus.in_valid = 1'b1;
                bus.W = wpl[i];
                bus.D = dpl[j];
                for (int t = 0; t < 50 && !bus.in_ready; t++) @(negedge clk);
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        bus.D = {$urandom, $urandom};
        checkOutput({tag, "_drain_out_valid"}, bus.out_valid, 0);
        checkOutput({tag, "_drain_in_ready"}, bus.in_ready, 0);
        @(negedge clk);
        checkOutput({tag, "_out_valid"}, bus.out_valid, 1);
        checkOutput({tag, "_beats"}, beats, wp * dp);
        checkRows(tag);
    endtask

    task automatic finishJob(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.W         = '0;
        bus.D         = '0;
        clearPlanes();

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", bus.in_ready, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        for (int r = 0; r < N; r++) checkOutput($sformatf("reset_row%0d", r), rowS(r), 0);
        rst_n = 1'b1;

        $display("[TB] unsigned 1x1 all ones");
        clearPlanes();
        wpl[0] = '1;
        dpl[0] = '1;
        applyStimulus("t1", MODE_UNSIGNED, 1, 1, 0);
        checkOutput("t1_const_row0", rowS(0), 64);
        finishJob("t1");

        $display("[TB] bipolar 1x1");
        clearPlanes();
        dpl[0] = '1;
        applyStimulus("t2", MODE_BIPOLAR, 1, 1, 0);
        checkOutput("t2_const_row63", rowS(63), -64);
        finishJob("t2");

        $display("[TB] signed 2x2 W=-1 D=+1");
        clearPlanes();
        wpl[0] = '1;
        wpl[1] = '1;
        dpl[0] = '1;
        applyStimulus("t3", MODE_SIGNED, 2, 2, 0);
        checkOutput("t3_const_row7", rowS(7), -64);
        finishJob("t3");

        $display("[TB] signed 2x2 W=-2 D=-2");
        clearPlanes();
        wpl[1] = '1;
        dpl[1] = '1;
        applyStimulus("t4", MODE_SIGNED, 2, 2, 0);
        checkOutput("t4_const_row0", rowS(0), 256);
        finishJob("t4");

        $display("[TB] unsigned 3x2 with gaps, then backpressure");
        clearPlanes();
        wpl[0][5*N] = 1'b1;
        wpl[2][5*N] = 1'b1;
        dpl[0][0]   = 1'b1;
        dpl[1][0]   = 1'b1;
        applyStimulus("t5", MODE_UNSIGNED, 3, 2, 1);
        checkOutput("t5_const_row5", rowS(5), 15);
        checkOutput("t5_const_row4", rowS(4), 0);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            @(negedge clk);
            checkOutput($sformatf("bp%0d_out_valid", c), bus.out_valid, 1);
            checkOutput($sformatf("bp%0d_in_ready", c), bus.in_ready, 0);
            checkOutput($sformatf("bp%0d_busy", c), busy, 1);
            checkOutput($sformatf("bp%0d_row5", c), rowS(5), 15);
        end
        start = 1'b0;
        finishJob("t5");
        @(negedge clk);
        checkOutput("bp_stays_idle", busy, 0);

        $display("[TB] clamped precisions");
        randomPlanes();
        applyStimulus("clamp", MODE_SIGNED, 0, 15, 0);
        finishJob("clamp");

        $display("[TB] random jobs");
        for (int n = 0; n < 8; n++) begin
            randomPlanes();
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            applyStimulus($sformatf("rnd%0d", n), mode_e'($urandom_range(3)),
                          int'($urandom_range(MAXPREC, 1)), int'($urandom_range(MAXPREC, 1)), 2);
            if (n == 3) begin
                start = 1'b1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                start = 1'b0;
                bus.out_ready = 1'b0;
                checkOutput("done_start_ignored_a", busy, 0);
                @(negedge clk);
                checkOutput("done_start_ignored_b", busy, 0);
            end else begin
                finishJob($sformatf("rnd%0d", n));
            end
        end

        $display("[TB] reset during a 4-beat job");
        randomPlanes();
        @(negedge clk);
        start = 1'b1;
        mode  = MODE_UNSIGNED;
        wprec = PW'(2);
        dprec = PW'(2);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.in_valid = 1'b1;
            bus.W = wpl[b / 2];
            bus.D = dpl[b % 2];
            @(negedge clk);
        end
        bus.W = wpl[1];
        bus.D = dpl[0];
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        for (int r = 0; r < N; r++) checkOutput($sformatf("rst_row%0d", r), rowS(r), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        applyStimulus("post_rst", MODE_UNSIGNED, 2, 2, 0);
        finishJob("post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
